// File: rtl/ifu_isram.sv
// ifu_isram: read-only instruction memory slave for the fetch unit.
// Reads are answered as bursts of arlen+1 beats after RD_LAT idle cycles.
// Writes are accepted and always answered with SLVERR.
// Contents are loaded only through the side load port.
module ifu_isram #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    // read address channel
    input  logic [31:0]           araddr,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    // read data channel
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rlast,
    // write channels (always refused with SLVERR)
    input  logic                  awvalid,
    output logic                  awready,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // load port
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam int          LAT_W   = $clog2(RD_LAT + 2);
    localparam logic [32:0] SPAN    = 33'(1) << (DEPTH_LOG2 + 2);
    localparam logic [1:0]  RESP_OK = 2'b00;
    localparam logic [1:0]  RESP_SL = 2'b10;
    localparam logic [1:0]  RESP_DE = 2'b11;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [LAT_W-1:0]      LAT_ONE = 1;
    localparam logic [LAT_W-1:0]      LAT_INIT = LAT_W'(RD_LAT);

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;
    typedef enum logic       {W_IDLE, W_RESP}        w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t               r_state, r_next;
    logic [LAT_W-1:0]       lat_cnt;
    logic [7:0]             beat_cnt;
    logic [DEPTH_LOG2-1:0]  word_idx;
    logic [1:0]             burst_resp;

    // AR decode, only meaningful in the handshake cycle
    logic [31:0]            ar_off;
    logic [DEPTH_LOG2-1:0]  ar_idx;
    logic [1:0]             ar_resp;

    // next beat to be presented on R
    logic                   fetch_en;
    logic [DEPTH_LOG2-1:0]  fetch_idx;
    logic [1:0]             fetch_resp;
    logic                   fetch_last;

    w_state_t               w_state, w_next;
    logic                   aw_seen, w_seen;
    logic                   aw_hs, w_hs;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    assign ar_off  = araddr - BASE_ADDR;
    assign ar_idx  = ar_off[DEPTH_LOG2+1:2];

    // Classify the request; alignment/size/length errors outrank range errors.
    always_comb begin
        ar_resp = RESP_OK;
        if (araddr[1:0] != 2'b00 || arsize != 3'b010 || arlen > 8'd15)
            ar_resp = RESP_SL;
        else if ({1'b0, ar_off} >= SPAN)
            ar_resp = RESP_DE;
    end

    // Load port writes the array; it is the only path that modifies it.
    // NOTE: the array has no reset so it can map onto block RAM; its contents
    // are defined only by what the load port has written.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    // Read FSM state register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state and selection of the beat to present next.
    always_comb begin
        r_next     = r_state;
        fetch_en   = 1'b0;
        fetch_idx  = word_idx;
        fetch_resp = burst_resp;
        fetch_last = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (arvalid) begin
                    if (RD_LAT == 0) begin
                        r_next     = R_DATA;
                        fetch_en   = 1'b1;
                        fetch_idx  = ar_idx;
                        fetch_resp = ar_resp;
                        fetch_last = (arlen == 8'd0);
                    end else begin
                        r_next = R_LAT;
                    end
                end
            end
            R_LAT: begin
                if (lat_cnt == LAT_ONE) begin
                    r_next     = R_DATA;
                    fetch_en   = 1'b1;
                    fetch_last = (beat_cnt == 8'd0);
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        fetch_en   = 1'b1;
                        fetch_idx  = word_idx + IDX_ONE;
                        fetch_last = (beat_cnt == 8'd1);
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Burst bookkeeping and the registered R channel payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt    <= '0;
            beat_cnt   <= '0;
            word_idx   <= '0;
            burst_resp <= RESP_OK;
            rdata      <= '0;
            rresp      <= RESP_OK;
            rlast      <= 1'b0;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                lat_cnt    <= LAT_INIT;
                beat_cnt   <= arlen;
                word_idx   <= ar_idx;
                burst_resp <= ar_resp;
            end else if (r_state == R_LAT) begin
                lat_cnt <= lat_cnt - LAT_ONE;
            end

            if (r_state == R_DATA && rready && !rlast) begin
                word_idx <= fetch_idx;
                beat_cnt <= beat_cnt - 8'd1;
            end

            if (fetch_en) begin
                rdata <= (fetch_resp == RESP_OK) ? mem[fetch_idx] : 32'h0;
                rresp <= fetch_resp;
                rlast <= fetch_last;
            end else if (r_state == R_DATA && rready && rlast) begin
                rlast <= 1'b0;
            end
        end
    end

    // Write side: AW and W are taken independently, one of each per response.
    assign awready = (w_state == W_IDLE) && !aw_seen;
    assign wready  = (w_state == W_IDLE) && !w_seen;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign bvalid  = (w_state == W_RESP);
    assign bresp   = bvalid ? RESP_SL : RESP_OK;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state: respond once both halves have arrived.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if ((aw_seen || aw_hs) && (w_seen || w_hs)) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Remember which half of the write has already been handshaken.
    always_ff @(posedge clk) begin
        if (reset || w_next == W_RESP) begin
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
        end else begin
            aw_seen <= aw_seen || aw_hs;
            w_seen  <= w_seen || w_hs;
        end
    end

endmodule
